// File: rtl/sgmii_pkg.sv
// ---------------------------------------------------------------------------
// sgmii_pkg
// Shared definitions for the SGMII transmit symbol sequencer:
//   - 8b10b code-group byte values (K codes are flagged separately by the
//     sequencer's sym_is_k output)
//   - the sequencer state enumeration
// ---------------------------------------------------------------------------
package sgmii_pkg;

  // Control (K) code groups
  localparam logic [7:0] K28_5 = 8'hBC;  // comma, starts /I/ and /C/ sets
  localparam logic [7:0] K27_7 = 8'hFB;  // /S/ start of packet
  localparam logic [7:0] K29_7 = 8'hFD;  // /T/ end of packet
  localparam logic [7:0] K23_7 = 8'hF7;  // /R/ carrier extend
  localparam logic [7:0] K30_7 = 8'hFE;  // /V/ error propagation

  // Data (D) code groups
  localparam logic [7:0] D16_2 = 8'h50;  // /I2/ second symbol, negative RD
  localparam logic [7:0] D5_6  = 8'hC5;  // /I1/ second symbol, positive RD
  localparam logic [7:0] D21_5 = 8'hB5;  // /C1/ second symbol
  localparam logic [7:0] D2_2  = 8'h42;  // /C2/ second symbol

  // Frame framing bytes
  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  typedef enum logic [3:0] {
    IDLE_K,  // K28.5 of an idle ordered set
    IDLE_D,  // D5.6 / D16.2 of an idle ordered set; arbitration point
    CFG,     // auto-negotiation /C1/ /C2/ ordered sets
    SOP,     // /S/
    PRE,     // preamble bytes
    SFD_ST,  // start-of-frame delimiter
    DATA,    // frame bytes from the source
    PAD,     // zero pad up to the minimum payload
    EPD_T,   // /T/
    EPD_R    // /R/, once or twice to restore even alignment
  } state_e;

endpackage

// File: rtl/sgmii_tx_sequencer.sv
// ---------------------------------------------------------------------------
// sgmii_tx_sequencer
// Produces one 8b10b symbol per sgmii_clk_in cycle for the SGMII transmit
// encoder, arbitrating between idle ordered sets, auto-negotiation /C/
// ordered sets and Ethernet frames (wrapped with /S/, preamble, SFD, pad,
// /T/ and /R/).
//
// Ports
//   sgmii_clk_in  in   symbol clock
//   reset         in   synchronous, active-high
//   an_enable     in   send /C/ ordered sets instead of idle/frames
//   an_config     in   16-bit auto-negotiation config word
//   tx_disp       in   encoder running disparity (1 = positive)
//   frm_valid     in   frame byte available
//   frm_data      in   frame byte
//   frm_last      in   last byte of frame
//   frm_ready     out  byte accepted this cycle (with frm_valid)
//   sym_value     out  registered symbol byte
//   sym_is_k      out  registered K-code flag
//   frame_done    out  registered pulse aligned with /T/
//   underrun      out  registered pulse aligned with /V/ on source starvation
// ---------------------------------------------------------------------------
module sgmii_tx_sequencer
  import sgmii_pkg::*;
#(
  parameter int MIN_PAYLOAD  = 60,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        sgmii_clk_in,
  input  logic        reset,
  input  logic        an_enable,
  input  logic [15:0] an_config,
  input  logic        tx_disp,
  input  logic        frm_valid,
  input  logic [7:0]  frm_data,
  input  logic        frm_last,
  output logic        frm_ready,
  output logic [7:0]  sym_value,
  output logic        sym_is_k,
  output logic        frame_done,
  output logic        underrun
);

  localparam logic [16:0] MIN_CNT   = 17'(MIN_PAYLOAD);
  // /S/ takes the first preamble slot, so only PREAMBLE_LEN-1 0x55 bytes
  localparam logic [7:0]  PRE_SLOTS = 8'(PREAMBLE_LEN - 1);

  state_e      state_q, state_d;
  logic        pos_q;                 // slot parity, 0 = even
  logic [15:0] cnt_q, cnt_d;          // DATA + PAD byte count
  logic [7:0]  pre_q, pre_d;          // preamble bytes emitted
  logic [2:0]  cfg_idx_q, cfg_idx_d;  // position within the 8-symbol /C1//C2/ cycle
  logic [15:0] cfg_q, cfg_d;          // config word latched at each K28.5

  logic [7:0]  sel_value;
  logic        sel_is_k;
  logic        sel_done;
  logic        sel_underrun;

  logic [15:0] cnt_inc;
  logic [16:0] cnt_plus1;

  // Saturating increment; the 17-bit sum keeps the length compare exact.
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign cnt_plus1 = {1'b0, cnt_q} + 17'd1;

  assign frm_ready = (state_q == DATA);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    cfg_idx_d    = cfg_idx_q;
    cfg_d        = cfg_q;
    sel_value    = D16_2;
    sel_is_k     = 1'b0;
    sel_done     = 1'b0;
    sel_underrun = 1'b0;

    case (state_q)
      IDLE_K: begin
        sel_value = K28_5;
        sel_is_k  = 1'b1;
        state_d   = IDLE_D;
      end

      IDLE_D: begin
        // Second idle symbol flips or keeps the running disparity as needed.
        sel_value = tx_disp ? D5_6 : D16_2;
        if (an_enable) begin
          state_d   = CFG;
          cfg_idx_d = 3'd0;
        end else if (frm_valid) begin
          state_d = SOP;
        end else begin
          state_d = IDLE_K;
        end
      end

      CFG: begin
        cfg_idx_d = cfg_idx_q + 3'd1;
        case (cfg_idx_q[1:0])
          2'd0: begin
            sel_value = K28_5;
            sel_is_k  = 1'b1;
            cfg_d     = an_config;
          end
          2'd1: sel_value = cfg_idx_q[2] ? D2_2 : D21_5;
          2'd2: sel_value = cfg_q[7:0];
          2'd3: begin
            sel_value = cfg_q[15:8];
            // Only a complete ordered set may be abandoned.
            if (!an_enable) state_d = IDLE_K;
          end
        endcase
      end

      SOP: begin
        sel_value = K27_7;
        sel_is_k  = 1'b1;
        cnt_d     = 16'd0;
        pre_d     = 8'd0;
        state_d   = (PRE_SLOTS != 8'd0) ? PRE : SFD_ST;
      end

      PRE: begin
        sel_value = PREAMBLE;
        pre_d     = pre_q + 8'd1;
        if (pre_q + 8'd1 >= PRE_SLOTS) state_d = SFD_ST;
      end

      SFD_ST: begin
        sel_value = SFD;
        state_d   = DATA;
      end

      DATA: begin
        if (frm_valid) begin
          sel_value = frm_data;
          cnt_d     = cnt_inc;
          if (frm_last) state_d = (cnt_plus1 < MIN_CNT) ? PAD : EPD_T;
        end else begin
          // Source starved mid-frame: poison the frame with /V/ and close it.
          sel_value    = K30_7;
          sel_is_k     = 1'b1;
          sel_underrun = 1'b1;
          state_d      = EPD_T;
        end
      end

      PAD: begin
        sel_value = 8'h00;
        cnt_d     = cnt_inc;
        if (cnt_plus1 >= MIN_CNT) state_d = EPD_T;
      end

      EPD_T: begin
        sel_value = K29_7;
        sel_is_k  = 1'b1;
        sel_done  = 1'b1;
        state_d   = EPD_R;
      end

      EPD_R: begin
        sel_value = K23_7;
        sel_is_k  = 1'b1;
        // An /R/ in an odd slot puts the next K28.5 on even; otherwise repeat.
        state_d   = pos_q ? IDLE_K : EPD_R;
      end

      default: state_d = IDLE_K;
    endcase
  end

  always_ff @(posedge sgmii_clk_in) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE_K;
      pos_q      <= 1'b0;
      cnt_q      <= 16'd0;
      pre_q      <= 8'd0;
      cfg_idx_q  <= 3'd0;
      cfg_q      <= 16'd0;
      sym_value  <= D16_2;
      sym_is_k   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= ~pos_q;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      cfg_idx_q  <= cfg_idx_d;
      cfg_q      <= cfg_d;
      sym_value  <= sel_value;
      sym_is_k   <= sel_is_k;
      frame_done <= sel_done;
      underrun   <= sel_underrun;
    end
  end

endmodule

// File: tb/tb_sgmii_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sgmii_tx_sequencer
// Self-checking bench for sgmii_tx_sequencer. A stream-level reference model
// predicts every output symbol from the inputs it drives; literal checks on
// captured output pin the idle, /C/ and frame layouts independently.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sgmii_tx_sequencer;
  import sgmii_pkg::*;

  localparam int MIN_P = 60;
  localparam int PRE_L = 7;

  logic        sgmii_clk_in = 1'b0;
  logic        reset        = 1'b1;
  logic        an_enable    = 1'b0;
  logic [15:0] an_config    = 16'h0000;
  logic        tx_disp      = 1'b0;
  logic        frm_valid    = 1'b0;
  logic [7:0]  frm_data     = 8'h00;
  logic        frm_last     = 1'b0;
  logic        frm_ready;
  logic [7:0]  sym_value;
  logic        sym_is_k;
  logic        frame_done;
  logic        underrun;

  sgmii_tx_sequencer #(.MIN_PAYLOAD(MIN_P), .PREAMBLE_LEN(PRE_L)) dut (
    .sgmii_clk_in(sgmii_clk_in), .reset(reset),
    .an_enable(an_enable), .an_config(an_config), .tx_disp(tx_disp),
    .frm_valid(frm_valid), .frm_data(frm_data), .frm_last(frm_last),
    .frm_ready(frm_ready), .sym_value(sym_value), .sym_is_k(sym_is_k),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 sgmii_clk_in = ~sgmii_clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of upcoming symbols ----------------
  typedef enum {TK_FIX, TK_CFGK, TK_CFGLO, TK_CFGHI} tok_kind_e;
  typedef struct {
    tok_kind_e  kind;
    logic [7:0] val;
    logic       k;
    logic       done;
    logic       und;
  } tok_t;

  tok_t        mq[$];
  bit          m_live    = 0;
  bit          m_in_data = 0;  // frame body slots follow once mq drains
  bit          m_d_next  = 0;  // next idle slot is the D half
  bit          m_pos     = 0;  // parity of the slot being produced
  bit          m_cfg_alt = 0;  // next /C/ half is /C2/
  logic [15:0] m_cfg     = 16'h0;
  int          m_bytes   = 0;
  logic [7:0]  e_val     = 8'h50;
  logic        e_k = 0, e_done = 0, e_und = 0;
  bit          rand_disp = 0;

  function automatic tok_t mk(tok_kind_e kd, logic [7:0] v, logic k, logic d, logic u);
    tok_t t;
    t.kind = kd; t.val = v; t.k = k; t.done = d; t.und = u;
    return t;
  endfunction

  task automatic push_cfg_half();
    mq.push_back(mk(TK_CFGK, 8'hBC, 1, 0, 0));
    mq.push_back(mk(TK_FIX, m_cfg_alt ? 8'h42 : 8'hB5, 0, 0, 0));
    mq.push_back(mk(TK_CFGLO, 8'h00, 0, 0, 0));
    mq.push_back(mk(TK_CFGHI, 8'h00, 0, 0, 0));
    m_cfg_alt = ~m_cfg_alt;
  endtask

  // /T/ follows `gap` slots after the current one; /R/ count keeps idle even.
  task automatic push_end(input int gap);
    int r_slot;
    r_slot = int'(m_pos) + gap + 2;
    mq.push_back(mk(TK_FIX, 8'hFD, 1, 1, 0));
    mq.push_back(mk(TK_FIX, 8'hF7, 1, 0, 0));
    if (r_slot % 2 == 0) mq.push_back(mk(TK_FIX, 8'hF7, 1, 0, 0));
  endtask

  always @(posedge sgmii_clk_in) begin : model
    tok_t t;
    int   pad;
    if (reset) begin
      mq.delete();
      m_in_data = 0; m_d_next = 0; m_pos = 0; m_cfg_alt = 0;
      e_val = 8'h50; e_k = 0; e_done = 0; e_und = 0;
      m_live = 1;
    end else if (m_live) begin
      e_done = 0; e_und = 0;
      if (mq.size() > 0) begin
        t = mq.pop_front();
        case (t.kind)
          TK_FIX:   begin e_val = t.val; e_k = t.k; e_done = t.done; e_und = t.und; end
          TK_CFGK:  begin m_cfg = an_config; e_val = 8'hBC; e_k = 1; end
          TK_CFGLO: begin e_val = m_cfg[7:0]; e_k = 0; end
          TK_CFGHI: begin
            e_val = m_cfg[15:8]; e_k = 0;
            if (an_enable) push_cfg_half();
          end
        endcase
      end else if (m_in_data) begin
        if (frm_valid) begin
          e_val = frm_data; e_k = 0;
          m_bytes++;
          if (frm_last) begin
            m_in_data = 0;
            pad = (m_bytes < MIN_P) ? MIN_P - m_bytes : 0;
            repeat (pad) mq.push_back(mk(TK_FIX, 8'h00, 0, 0, 0));
            push_end(pad);
          end
        end else begin
          e_val = 8'hFE; e_k = 1; e_und = 1;
          m_in_data = 0;
          push_end(0);
        end
      end else if (m_d_next) begin
        e_val = tx_disp ? 8'hC5 : 8'h50; e_k = 0;
        m_d_next = 0;
        if (an_enable) begin
          m_cfg_alt = 0;
          push_cfg_half();
        end else if (frm_valid) begin
          mq.push_back(mk(TK_FIX, 8'hFB, 1, 0, 0));
          repeat (PRE_L - 1) mq.push_back(mk(TK_FIX, 8'h55, 0, 0, 0));
          mq.push_back(mk(TK_FIX, 8'hD5, 0, 0, 0));
          m_in_data = 1;
          m_bytes   = 0;
        end
      end else begin
        e_val = 8'hBC; e_k = 1;
        m_d_next = 1;
      end
      m_pos = ~m_pos;
    end
  end

  // Single compare process: every cycle once the model is live.
  always @(negedge sgmii_clk_in) begin
    if (m_live) begin
      check("stream{val,k,done,und,ready}",
            {sym_value, sym_is_k, frame_done, underrun, frm_ready},
            {e_val, e_k, e_done, e_und, (mq.size() == 0) && m_in_data});
    end
  end

  // ---------------- capture of outputs with slot index since reset ----------------
  typedef struct {
    logic [7:0] v;
    logic       k;
    logic       d;
    logic       u;
    int         slot;
  } cap_t;

  cap_t cap[$];
  int   rel_slot = 0;

  always @(posedge sgmii_clk_in) begin
    if (reset) rel_slot = 0;
    else       rel_slot = rel_slot + 1;
  end

  always @(negedge sgmii_clk_in) begin
    cap_t c;
    if (rel_slot > 0) begin
      c.v = sym_value; c.k = sym_is_k; c.d = frame_done; c.u = underrun;
      c.slot = rel_slot - 1;
      cap.push_back(c);
    end
    if (rand_disp) tx_disp = 1'($urandom_range(0, 1));
  end

  function automatic cap_t cap_at(input int idx);
    cap_t c;
    c.v = 8'hXX; c.k = 1'bx; c.d = 1'bx; c.u = 1'bx; c.slot = -1;
    if (idx >= 0 && idx < cap.size()) c = cap[idx];
    return c;
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [7:0] fb[256];

  task automatic send_frame(input int len, input int drop_at, input int abort_at);
    int i = 0;
    int guard = 0;
    bit take;
    frm_valid = 1; frm_data = fb[0]; frm_last = (len == 1);
    while (i < len) begin
      take = frm_ready && frm_valid;
      @(negedge sgmii_clk_in);
      guard++;
      if (take) i++;
      if (guard > 400) begin
        check("frame_accept_timeout", i, len);
        break;
      end
      if (abort_at >= 0 && i == abort_at) begin
        reset = 1; frm_valid = 0; frm_last = 0;
        @(negedge sgmii_clk_in); #1;
        check("reset_mid_data_sym", {sym_value, sym_is_k}, {8'h50, 1'b0});
        check("reset_mid_data_ready", frm_ready, 1'b0);
        reset = 0;
        break;
      end
      if (drop_at >= 0 && i == drop_at) break;
      if (i < len) begin frm_data = fb[i]; frm_last = (i == len - 1); end
    end
    frm_valid = 0; frm_last = 0;
  endtask

  // Literal layout check of one frame found at/after capture index `mark`.
  task automatic verify_frame(input int mark, input int len, input int drop);
    int fb_idx = -1;
    int p, errs, nb, npad, nr, ndone, nund;
    cap_t c;
    for (int i = mark; i < cap.size(); i++)
      if (cap[i].v == 8'hFB && cap[i].k) begin fb_idx = i; break; end
    if (fb_idx < 0) begin
      check("frame_sop_found", 0, 1);
      return;
    end
    p = fb_idx + 1; errs = 0;
    for (int i = 0; i < PRE_L - 1; i++) begin
      c = cap_at(p++); if ({c.v, c.k} !== {8'h55, 1'b0}) errs++;
    end
    c = cap_at(p++); if ({c.v, c.k} !== {8'hD5, 1'b0}) errs++;
    check("preamble_sfd", errs, 0);
    nb = (drop >= 0) ? drop : len;
    errs = 0;
    for (int i = 0; i < nb; i++) begin
      c = cap_at(p++); if ({c.v, c.k} !== {fb[i], 1'b0}) errs++;
    end
    check("payload", errs, 0);
    if (drop >= 0) begin
      c = cap_at(p++);
      check("underrun_sym", {c.v, c.k, c.u}, {8'hFE, 1'b1, 1'b1});
    end else begin
      npad = (len < MIN_P) ? MIN_P - len : 0;
      errs = 0;
      for (int i = 0; i < npad; i++) begin
        c = cap_at(p++); if ({c.v, c.k} !== {8'h00, 1'b0}) errs++;
      end
      c = cap_at(p);
      check("pad_then_t", errs + (c.v !== 8'hFD), 0);
    end
    c = cap_at(p++);
    check("epd_t", {c.v, c.k, c.d}, {8'hFD, 1'b1, 1'b1});
    nr = 0;
    while (p < cap.size() && cap[p].v == 8'hF7 && cap[p].k) begin nr++; p++; end
    check("epd_r_count_1_or_2", (nr == 1 || nr == 2), 1);
    c = cap_at(p);
    check("idle_k_even_after_r", {c.v, c.k, c.slot[0]}, {8'hBC, 1'b1, 1'b0});
    ndone = 0; nund = 0;
    for (int i = fb_idx; i <= p; i++) begin
      c = cap_at(i); ndone += int'(c.d); nund += int'(c.u);
    end
    check("frame_done_pulses", ndone, 1);
    check("underrun_pulses", nund, (drop >= 0) ? 1 : 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int mark, idx, b5_idx, fb_idx, len, drop;
    bit found;
    cap_t c;
    logic [7:0] cfg_tab [8];
    cfg_tab = '{8'hBC, 8'hB5, 8'hA0, 8'h01, 8'hBC, 8'h42, 8'hA0, 8'h01};

    // Reset values
    reset = 1;
    repeat (3) @(negedge sgmii_clk_in);
    check("rst_sym_value", sym_value, 8'h50);
    check("rst_sym_is_k", sym_is_k, 1'b0);
    check("rst_frm_ready", frm_ready, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    reset = 0;

    // Idle with tx_disp=0: BC(K) on even slots, 50 on odd
    mark = cap.size();
    repeat (20) @(negedge sgmii_clk_in);
    #1;
    check("idle_first_slot", cap_at(mark).slot, 0);
    for (int j = 0; j < 20; j++) begin
      c = cap_at(mark + j);
      check("idle_alternation", {c.v, c.k}, (j % 2 == 0) ? {8'hBC, 1'b1} : {8'h50, 1'b0});
    end

    // Auto-negotiation /C1/ /C2/ sequence
    an_config = 16'h01A0; an_enable = 1;
    mark = cap.size();
    repeat (30) @(negedge sgmii_clk_in);
    #1;
    idx = -1;
    for (int i = mark; i < cap.size() - 1; i++)
      if (cap[i].v == 8'hBC && cap[i].k && cap[i+1].v == 8'hB5) begin idx = i; break; end
    check("cfg_found", idx >= 0, 1);
    if (idx >= 0) begin
      check("cfg_first_even", cap_at(idx).slot[0], 1'b0);
      for (int j = 0; j < 16; j++) begin
        c = cap_at(idx + j);
        check("cfg_pattern", {c.v, c.k}, {cfg_tab[j % 8], (j % 4 == 0)});
      end
    end
    // Drop an_enable once D21.5 is on the output: the set completes, then idle
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge sgmii_clk_in); #1;
      if (cap[$].v == 8'hB5 && !cap[$].k) found = 1;
    end
    check("cfg_b5_seen", found, 1);
    an_enable = 0;
    mark = cap.size();
    repeat (4) @(negedge sgmii_clk_in);
    #1;
    check("cfg_tail_lo", {cap_at(mark).v, cap_at(mark).k}, {8'hA0, 1'b0});
    check("cfg_tail_hi", {cap_at(mark+1).v, cap_at(mark+1).k}, {8'h01, 1'b0});
    check("cfg_exit_k", {cap_at(mark+2).v, cap_at(mark+2).k}, {8'hBC, 1'b1});
    check("cfg_exit_d", {cap_at(mark+3).v, cap_at(mark+3).k}, {8'h50, 1'b0});

    // 64-byte frame 0x00..0x3F
    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    mark = cap.size();
    send_frame(64, -1, -1);
    repeat (80) @(negedge sgmii_clk_in);
    #1;
    verify_frame(mark, 64, -1);

    // 10-byte frame: 50 pad bytes
    for (int i = 0; i < 10; i++) fb[i] = 8'($urandom);
    mark = cap.size();
    send_frame(10, -1, -1);
    repeat (80) @(negedge sgmii_clk_in);
    #1;
    verify_frame(mark, 10, -1);

    // Source starves after 20 bytes
    for (int i = 0; i < 40; i++) fb[i] = 8'($urandom);
    mark = cap.size();
    send_frame(40, 20, -1);
    repeat (80) @(negedge sgmii_clk_in);
    #1;
    verify_frame(mark, 40, 20);

    // an_enable and frm_valid together at the decision: /C/ wins
    for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
    mark = cap.size();
    an_config = 16'h1234; an_enable = 1;
    frm_valid = 1; frm_data = fb[0]; frm_last = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sgmii_clk_in);
      check("pri_frm_ready_low", frm_ready, 1'b0);
    end
    an_enable = 0;
    send_frame(12, -1, -1);
    repeat (80) @(negedge sgmii_clk_in);
    #1;
    b5_idx = -1; fb_idx = -1;
    for (int i = cap.size() - 1; i >= mark; i--) begin
      if (cap[i].v == 8'hB5 && !cap[i].k) b5_idx = i;
      if (cap[i].v == 8'hFB && cap[i].k)  fb_idx = i;
    end
    check("pri_cfg_before_sop", (b5_idx >= 0) && (fb_idx > b5_idx), 1);
    verify_frame(mark, 12, -1);

    // Reset in the middle of DATA drops the frame
    for (int i = 0; i < 30; i++) fb[i] = 8'($urandom);
    send_frame(30, -1, 5);
    repeat (10) @(negedge sgmii_clk_in);

    // Randomized traffic against the model
    rand_disp = 1;
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        an_config = 16'($urandom);
        an_enable = 1;
        repeat ($urandom_range(1, 20)) @(negedge sgmii_clk_in);
        an_enable = 0;
      end
      repeat ($urandom_range(0, 10)) @(negedge sgmii_clk_in);
      len = $urandom_range(1, 90);
      drop = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1;
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
      mark = cap.size();
      send_frame(len, drop, -1);
      repeat (70) @(negedge sgmii_clk_in);
      #1;
      verify_frame(mark, len, drop);
    end
    rand_disp = 0;
    repeat (5) @(negedge sgmii_clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
